// File: rtl/car_lane_ctrl.sv
// One lane of cars for a frogger-style game: moves cars with a wrapping
// X position, draws them, and raises a sticky hit flag when the frog overlaps a car.

module car_lane_car #(
   parameter int c_GAME_WIDTH = 640,
   parameter int c_CAR_WIDTH  = 32,
   parameter int c_OFFSET     = 0,
   parameter int XW           = 12
) (
   input  logic [XW-1:0] i_head_x,
   input  logic [9:0]    i_col,
   input  logic [9:0]    i_frog_x,
   output logic          o_col_in,
   output logic          o_frog_ovl
);
   localparam logic [XW-1:0] GW        = XW'(c_GAME_WIDTH);
   localparam logic [XW-1:0] OFF       = XW'(c_OFFSET);
   localparam logic [XW-1:0] CW        = XW'(c_CAR_WIDTH);
   localparam logic [XW-1:0] HIT_SPAN  = XW'(2 * c_CAR_WIDTH - 1);
   localparam logic [XW-1:0] FROG_BIAS = XW'(c_CAR_WIDTH - 1 + c_GAME_WIDTH);

   logic [XW-1:0] sum, car_x, col, d, t;

   always_comb begin
      sum   = i_head_x + OFF;
      car_x = (sum >= GW) ? sum - GW : sum;
      col   = XW'(i_col);
      d     = (col >= car_x) ? col - car_x : col + GW - car_x;
      o_col_in = (d < CW);
      // Bias by GW keeps the difference positive before the wrap reduction.
      t = (XW'(i_frog_x) + FROG_BIAS - car_x) % GW;
      o_frog_ovl = (t < HIT_SPAN);
   end
endmodule

module car_lane_ctrl #(
   parameter int c_GAME_WIDTH  = 640,
   parameter int c_NUM_CARS    = 4,
   parameter int c_CAR_SPACING = 160,
   parameter int c_CAR_WIDTH   = 32,
   parameter int c_CAR_HEIGHT  = 32,
   parameter int c_DIRECTION   = 0,
   parameter int c_INITIAL_X   = 0,
   parameter int c_SPEED_BASE  = 1650000
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       i_Game_Active,
   input  logic       i_Pause,
   input  logic [2:0] i_Level,
   input  logic [9:0] i_Col_Count_Div,
   input  logic [9:0] i_Row_Count_Div,
   input  logic [9:0] i_Lane_Y,
   input  logic [9:0] i_Frog_X,
   input  logic [9:0] i_Frog_Y,
   input  logic       i_Hit_Ack,
   output logic       o_Draw_car,
   output logic [9:0] o_Head_X,
   output logic [9:0] o_Lane_Y,
   output logic       o_Hit
);
   localparam int XW    = $clog2(1024 + c_GAME_WIDTH + c_CAR_WIDTH + c_CAR_HEIGHT) + 1;
   localparam int CNT_W = $clog2(c_SPEED_BASE + 1) + 1;
   localparam int SW    = (c_NUM_CARS > 1) ? $clog2(c_NUM_CARS) : 1;

   localparam logic [CNT_W-1:0] BASE   = CNT_W'(c_SPEED_BASE);
   localparam logic [9:0]       X_LAST = 10'(c_GAME_WIDTH - 1);
   localparam logic [9:0]       INIT_X = 10'(c_INITIAL_X);
   localparam logic [XW-1:0]    CH     = XW'(c_CAR_HEIGHT);
   localparam logic [SW-1:0]    IDX_LAST = SW'(c_NUM_CARS - 1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t           state_q, state_d;
   logic [9:0]       head_q, head_d;
   logic [9:0]       lane_q, lane_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SW-1:0]    idx_q, idx_d;
   logic             hit_q, hit_d;
   logic             draw_q, draw_d;

   logic [CNT_W-1:0]      period;
   logic [9:0]            step_x;
   logic [XW-1:0]         head_x, row_x, lane_x, fy_x, dy;
   logic                  row_in, fy_in;
   logic [c_NUM_CARS-1:0] col_in, frog_ovl;

   assign head_x = XW'(head_q);

   for (genvar k = 0; k < c_NUM_CARS; k++) begin : g_car
      car_lane_car #(
         .c_GAME_WIDTH(c_GAME_WIDTH),
         .c_CAR_WIDTH (c_CAR_WIDTH),
         .c_OFFSET    (k * c_CAR_SPACING),
         .XW          (XW)
      ) u_car (
         .i_head_x  (head_x),
         .i_col     (i_Col_Count_Div),
         .i_frog_x  (i_Frog_X),
         .o_col_in  (col_in[k]),
         .o_frog_ovl(frog_ovl[k])
      );
   end

   always_comb begin
      period = BASE >> i_Level;
      if (period == '0) period = CNT_W'(1);
      if (c_DIRECTION == 0) step_x = (head_q == X_LAST) ? 10'd0 : head_q + 10'd1;
      else                  step_x = (head_q == 10'd0) ? X_LAST : head_q - 10'd1;
      row_x  = XW'(i_Row_Count_Div);
      lane_x = XW'(lane_q);
      fy_x   = XW'(i_Frog_Y);
      row_in = (row_x >= lane_x) && (row_x < lane_x + CH);
      dy     = (fy_x >= lane_x) ? fy_x - lane_x : lane_x - fy_x;
      fy_in  = (dy < CH);
   end

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      lane_d  = lane_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      hit_d   = hit_q;
      draw_d  = (|col_in) && row_in;

      case (state_q)
         IDLE: begin
            idx_d   = '0;
            state_d = LOAD;
         end
         LOAD: begin
            head_d  = INIT_X;
            lane_d  = i_Lane_Y;
            cnt_d   = '0;
            idx_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + SW'(1);
            if (!i_Pause) begin
               // Compare against the live period so a level change applies at once.
               if (cnt_q >= period) begin
                  cnt_d  = '0;
                  head_d = step_x;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_q == RUN && frog_ovl[idx_q] && fy_in) hit_d = 1'b1;
      if (i_Hit_Ack) hit_d = 1'b0;

      if (!i_Game_Active) begin
         state_d = IDLE;
         head_d  = INIT_X;
         cnt_d   = '0;
         idx_d   = '0;
         hit_d   = 1'b0;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q <= IDLE;
         head_q  <= INIT_X;
         lane_q  <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         hit_q   <= 1'b0;
         draw_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         lane_q  <= lane_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         hit_q   <= hit_d;
         draw_q  <= draw_d;
      end
   end

   assign o_Draw_car = draw_q;
   assign o_Head_X   = head_q;
   assign o_Lane_Y   = lane_q;
   assign o_Hit      = hit_q;
endmodule

// File: tb/tb_car_lane_ctrl.sv
// Bench for car_lane_ctrl: a right-moving and a left-moving lane share stimulus
// and are compared every cycle against an arithmetic model of the lane rules.

module tb_car_lane_ctrl;
   logic       clk = 1'b0;
   logic       rst_n, active, pause, ack;
   logic [2:0] level;
   logic [9:0] col, row, lane_in, fx, fy;
   logic       d_draw [2];
   logic [9:0] d_head [2];
   logic [9:0] d_lane [2];
   logic       d_hit  [2];

   int n_asserts = 0;
   int n_fail    = 0;

   int BASE [2] = '{4, 8};
   int DIR  [2] = '{0, 1};

   // model: phase 0=idle 1=load 2=run
   int mph [2], mhead [2], mlane [2], mcnt [2], midx [2];
   bit mhit [2], mdraw [2];

   always #5 clk = ~clk;

   car_lane_ctrl #(.c_SPEED_BASE(4), .c_DIRECTION(0)) u_right (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Game_Active(active), .i_Pause(pause),
      .i_Level(level), .i_Col_Count_Div(col), .i_Row_Count_Div(row),
      .i_Lane_Y(lane_in), .i_Frog_X(fx), .i_Frog_Y(fy), .i_Hit_Ack(ack),
      .o_Draw_car(d_draw[0]), .o_Head_X(d_head[0]), .o_Lane_Y(d_lane[0]), .o_Hit(d_hit[0]));

   car_lane_ctrl #(.c_SPEED_BASE(8), .c_DIRECTION(1)) u_left (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Game_Active(active), .i_Pause(pause),
      .i_Level(level), .i_Col_Count_Div(col), .i_Row_Count_Div(row),
      .i_Lane_Y(lane_in), .i_Frog_X(fx), .i_Frog_Y(fy), .i_Hit_Ack(ack),
      .o_Draw_car(d_draw[1]), .o_Head_X(d_head[1]), .o_Lane_Y(d_lane[1]), .o_Hit(d_hit[1]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   function automatic bit covers(int hx, int ly, int c, int r);
      bit h = 0;
      for (int k = 0; k < 4; k++) begin
         int x = (hx + k * 160) % 640;
         if ((c - x + 640) % 640 < 32) h = 1;
      end
      return h && r >= ly && r < ly + 32;
   endfunction

   function automatic bit frog_on(int hx, int k, int ly, int fxx, int fyy);
      int x  = (hx + k * 160) % 640;
      int dx = ((fxx + 31 - x) % 640 + 640) % 640;
      int dy = fyy - ly;
      return dx < 63 && dy < 32 && dy > -32;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         mph[m] = 0; mhead[m] = 0; mlane[m] = 0; mcnt[m] = 0;
         midx[m] = 0; mhit[m] = 0; mdraw[m] = 0;
      end
   endtask

   task automatic check_all(input string tag);
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("%s head%0d", tag, m), 32'(d_head[m]), 32'(mhead[m]));
         chk($sformatf("%s lane%0d", tag, m), 32'(d_lane[m]), 32'(mlane[m]));
         chk($sformatf("%s hit%0d",  tag, m), 32'(d_hit[m]),  32'(mhit[m]));
         chk($sformatf("%s draw%0d", tag, m), 32'(d_draw[m]), 32'(mdraw[m]));
      end
   endtask

   task automatic tick();
      int nph[2], nhead[2], nlane[2], ncnt[2], nidx[2];
      bit nhit[2], ndraw[2];
      for (int m = 0; m < 2; m++) begin
         int p = BASE[m] >> level;
         if (p < 1) p = 1;
         nph[m] = mph[m]; nhead[m] = mhead[m]; nlane[m] = mlane[m];
         ncnt[m] = mcnt[m]; nidx[m] = midx[m]; nhit[m] = mhit[m];
         ndraw[m] = covers(mhead[m], mlane[m], int'(col), int'(row));
         if (mph[m] == 2 && frog_on(mhead[m], midx[m], mlane[m], int'(fx), int'(fy))) nhit[m] = 1;
         if (ack) nhit[m] = 0;
         if (mph[m] == 0) begin
            nph[m] = 1; nidx[m] = 0;
         end else if (mph[m] == 1) begin
            nph[m] = 2; nhead[m] = 0; nlane[m] = int'(lane_in); ncnt[m] = 0; nidx[m] = 0;
         end else begin
            nidx[m] = (midx[m] + 1) % 4;
            if (!pause) begin
               if (mcnt[m] >= p) begin
                  ncnt[m]  = 0;
                  nhead[m] = DIR[m] ? (mhead[m] + 639) % 640 : (mhead[m] + 1) % 640;
               end else ncnt[m] = mcnt[m] + 1;
            end
         end
         if (!active) begin
            nph[m] = 0; nhead[m] = 0; ncnt[m] = 0; nidx[m] = 0; nhit[m] = 0;
         end
      end
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
         mph[m] = nph[m]; mhead[m] = nhead[m]; mlane[m] = nlane[m]; mcnt[m] = ncnt[m];
         midx[m] = nidx[m]; mhit[m] = nhit[m]; mdraw[m] = ndraw[m];
      end
      if (!rst_n) model_reset();
      #1;
      check_all("cyc");
   endtask

   task automatic rand_pixel();
      if ($urandom_range(0, 1) == 0) begin
         col = 10'((mhead[$urandom_range(0, 1)] + $urandom_range(0, 3) * 160
                    + $urandom_range(0, 40) + 636) % 640);
      end else begin
         col = 10'($urandom_range(0, 639));
      end
      row = 10'($urandom_range(190, 240));
   endtask

   initial begin
      bit got;
      int saved;
      rst_n = 0; active = 0; pause = 0; level = 0; ack = 0;
      col = 0; row = 0; lane_in = 10'd200; fx = 0; fy = 10'd600;
      model_reset();
      #2;
      check_all("reset");
      tick(); tick();
      rst_n = 1;
      repeat (3) tick();

      // first step timing and left wrap from 0
      active = 1;
      repeat (6) tick();
      chk("first_step_early", 32'(d_head[0]), 32'd0);
      tick();
      chk("first_step", 32'(d_head[0]), 32'd1);
      repeat (4) tick();
      chk("left_wrap_0_to_639", 32'(d_head[1]), 32'd639);

      // randomized run: level changes, pauses, frog excursions, acks
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) level = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 39) == 0) pause = ~pause;
         if ($urandom_range(0, 199) == 0) begin
            fx = 10'($urandom_range(0, 639));
            fy = 10'($urandom_range(170, 230));
         end else if ($urandom_range(0, 99) == 0) fy = 10'd600;
         ack = ($urandom_range(0, 19) == 0);
         rand_pixel();
         tick();
      end

      // right wrap 639 -> 0
      pause = 0; level = 3'd7; ack = 0; fy = 10'd600;
      got = 0;
      for (int i = 0; i < 1400 && !got; i++) begin
         rand_pixel();
         tick();
         if (d_head[0] == 10'd639) got = 1;
      end
      chk("reach_639", 32'(got), 32'd1);
      for (int i = 0; i < 4 && d_head[0] == 10'd639; i++) tick();
      chk("right_wrap_639_to_0", 32'(d_head[0]), 32'd0);

      // collision on car 2 with lane frozen
      pause = 1; ack = 1;
      tick();
      ack = 0;
      fx = 10'((mhead[0] + 320) % 640);
      fy = 10'(mlane[0]);
      got = 0;
      for (int i = 0; i < 5 && !got; i++) begin
         rand_pixel();
         tick();
         if (d_hit[0] === 1'b1) got = 1;
      end
      chk("hit_set", 32'(got), 32'd1);
      repeat (100) begin rand_pixel(); tick(); end
      chk("hit_sticky", 32'(d_hit[0]), 32'd1);
      ack = 1;
      tick();
      chk("hit_ack", 32'(d_hit[0]), 32'd0);
      ack = 0;
      got = 0;
      for (int i = 0; i < 5 && !got; i++) begin
         tick();
         if (d_hit[0] === 1'b1) got = 1;
      end
      chk("hit_reassert", 32'(got), 32'd1);

      // pause hold
      saved = mhead[0];
      repeat (50) begin rand_pixel(); tick(); end
      chk("pause_hold", 32'(d_head[0]), 32'(saved));
      chk("pause_hit", 32'(d_hit[0]), 32'd1);

      // asynchronous reset mid-count
      pause = 0; level = 0; fy = 10'd600;
      repeat (3) tick();
      rst_n = 0;
      #1;
      model_reset();
      check_all("async_rst");
      tick(); tick();
      rst_n = 1;
      repeat (20) begin rand_pixel(); tick(); end

      // game inactive forces idle
      active = 0;
      tick();
      chk("inactive_head", 32'(d_head[0]), 32'd0);
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule
